muldiv_sequencer: RTL and testbench

//  Iterative signed multiply/divide unit and its sequencer, beside the single-cycle ALU in EX.

---
 rtl/alu_pkg.sv | 13 +
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 175 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU-side types and constants, including the iterative mul/div sequencer state.
package alu_pkg;

    localparam int unsigned MULDIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add for multiply, restoring
// shift-subtract for divide. The quotient bit lands in acc_o[0].
module muldiv_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic                 op_div_i,
    input  logic [2*WIDTH:0]     acc_i,
    input  logic [WIDTH:0]       operand_i,
    output logic [2*WIDTH:0]     acc_o
);

    localparam int unsigned AW = 2 * WIDTH + 1;

    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] diff;
    logic [AW-1:0]    shl;

    always_comb begin : step
        sum  = {1'b0, acc_i[AW-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        shl  = {acc_i[AW-2:0], 1'b0};
        diff = {1'b0, shl[AW-1:WIDTH]} - {1'b0, operand_i};
        if (op_div_i) begin
            // Keep the trial subtraction only when the partial remainder stays non-negative
            if (!diff[WIDTH+1]) begin
                acc_o = {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = shl;
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide sequencer beside the EX ALU: stalls the pipe
// while running and returns registered results plus div0/overflow flags.
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div0,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = 2 * WIDTH + 1;

    muldiv_state_e    state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    acc_q, acc_d, step_acc;
    logic [WIDTH:0]   operand_q, operand_d;
    logic             op_div_q, op_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] result_lo_q, result_lo_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             div0_q, div0_d;
    logic             overflow_q, overflow_d;

    logic             idle_or_done, accept, last_step, b_zero;
    logic [WIDTH:0]   a_ext, b_ext, mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0] quot, rem;
    logic             mul_ovf, div_ovf;

    // Operand magnitudes are WIDTH+1 bits so |MIN| is representable
    always_comb begin : operand_prep
        idle_or_done = (state_q == IDLE) || (state_q == DONE);
        accept       = start && !flush && idle_or_done;
        last_step    = (count_q == CW'(WIDTH - 1));
        b_zero       = (b == '0);
        a_ext        = {a[WIDTH-1], a};
        b_ext        = {b[WIDTH-1], b};
        mag_a        = a[WIDTH-1] ? -a_ext : a_ext;
        mag_b        = b[WIDTH-1] ? -b_ext : b_ext;
    end

    // Sign application and overflow detection for the FIXUP cycle
    always_comb begin : fixup_calc
        prod_mag = acc_q[2*WIDTH-1:0];
        prod     = neg_res_q ? -prod_mag : prod_mag;
        quot     = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        mul_ovf  = acc_q[AW-1]
                 || !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1)
        div_ovf  = !neg_res_q && acc_q[WIDTH-1];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_div_i  (op_div_q),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (step_acc)
    );

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = (op_div && b_zero) ? DONE : RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN:     if (last_step) state_d = FIXUP;
                FIXUP:   state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin : outputs
        busy      = (state_q == RUN) || (state_q == FIXUP);
        done      = (state_q == DONE);
        stall     = busy || (start && idle_or_done);
        result_lo = result_lo_q;
        result_hi = result_hi_q;
        div0      = div0_q;
        overflow  = overflow_q;
    end

    always_comb begin : datapath_next
        count_d     = count_q;
        acc_d       = acc_q;
        operand_d   = operand_q;
        op_div_d    = op_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        div0_d      = div0_q;
        overflow_d  = overflow_q;
        if (accept) begin
            op_div_d  = op_div;
            neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
            operand_d = op_div ? mag_b : mag_a;
            acc_d     = {{(WIDTH+1){1'b0}}, (op_div ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0])};
            count_d   = '0;
            if (op_div && b_zero) begin
                result_lo_d = '0;
                result_hi_d = '0;
                div0_d      = 1'b1;
                overflow_d  = 1'b0;
            end
        end else if (!flush && state_q == RUN) begin
            acc_d   = step_acc;
            count_d = count_q + CW'(1);
        end else if (!flush && state_q == FIXUP) begin
            result_lo_d = op_div_q ? quot : prod[WIDTH-1:0];
            result_hi_d = op_div_q ? rem : prod[2*WIDTH-1:WIDTH];
            div0_d      = 1'b0;
            overflow_d  = op_div_q ? div_ovf : mul_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : datapath_reg
        if (rst) begin
            count_q     <= '0;
            acc_q       <= '0;
            operand_q   <= '0;
            op_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            div0_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            acc_q       <= acc_d;
            operand_q   <= operand_d;
            op_div_q    <= op_div_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            div0_q      <= div0_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are queued at issue
// and popped when done pulses.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        stall, busy, done, div0, overflow;
    logic [15:0] result_lo, result_hi;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dz;
        logic        ov;
        int          t;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_div    (op_div),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .div0      (div0),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(logic [15:0] lo, logic [15:0] hi, logic dz, logic ov);
        exp_t e;
        e.lo = lo; e.hi = hi; e.dz = dz; e.ov = ov; e.t = 0;
        return e;
    endfunction

    function automatic exp_t model(logic d, logic [15:0] aa, logic [15:0] bb);
        exp_t e;
        int va, vb, p, q, r;
        va = int'($signed(aa));
        vb = int'($signed(bb));
        e = mk(16'h0, 16'h0, 1'b0, 1'b0);
        if (!d) begin
            p = va * vb;
            e.lo = p[15:0];
            e.hi = p[31:16];
            e.ov = (p > 32767) || (p < -32768);
        end else if (vb == 0) begin
            e.dz = 1'b1;
        end else if (va == -32768 && vb == -1) begin
            e.lo = 16'h8000;
            e.ov = 1'b1;
        end else begin
            q = va / vb;
            r = va % vb;
            e.lo = q[15:0];
            e.hi = r[15:0];
        end
        return e;
    endfunction

    task automatic pop_compare();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done cyc=%0d got done=1 want no done", cyc);
            return;
        end
        e = sb_q.pop_front();
        last_exp = e;
        checks++;
        if (result_lo !== e.lo) begin
            failures++;
            $display("FAIL result_lo got=%h want=%h", result_lo, e.lo);
        end
        checks++;
        if (result_hi !== e.hi) begin
            failures++;
            $display("FAIL result_hi got=%h want=%h", result_hi, e.hi);
        end
        checks++;
        if (div0 !== e.dz) begin
            failures++;
            $display("FAIL div0 got=%b want=%b", div0, e.dz);
        end
        checks++;
        if (overflow !== e.ov) begin
            failures++;
            $display("FAIL overflow got=%b want=%b", overflow, e.ov);
        end
        checks++;
        if (cyc !== e.t) begin
            failures++;
            $display("FAIL done_latency got_cycle=%0d want_cycle=%0d", cyc, e.t);
        end
    endtask

    // Drives start for one cycle; returns #1 after the following edge
    task automatic issue(input logic d, input logic [15:0] aa, input logic [15:0] bb,
                         input bit push, input exp_t e);
        exp_t x;
        @(posedge clk);
        #1;
        start = 1'b1; op_div = d; a = aa; b = bb;
        if (push) begin
            x = e;
            x.t = cyc + ((d && bb == 16'h0) ? 1 : 18);
            sb_q.push_back(x);
        end
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_on_start got=%b want=1", stall);
        end
        if (done === 1'b1) pop_compare();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue_model(input logic d, input logic [15:0] aa, input logic [15:0] bb);
        issue(d, aa, bb, 1'b1, model(d, aa, bb));
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pop_compare();
                seen = 1'b1;
                checks++;
                if (stall !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_done got=%b want=0", stall);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout got=no done want=done within %0d cycles", max_cycles);
        end else begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse got=%b want=0 one cycle after done", done);
            end
        end
    endtask

    task automatic expect_no_done(input int n, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        checks++;
        if (got) begin
            failures++;
            $display("FAIL %s got=done pulse want=no done", tag);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if ({done, busy, stall, div0, overflow, result_lo, result_hi} !== 37'h0) begin
            failures++;
            $display("FAIL %s got done=%b busy=%b stall=%b div0=%b ovf=%b lo=%h hi=%h want all 0",
                     tag, done, busy, stall, div0, overflow, result_lo, result_hi);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_held");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset_released");
    endtask

    task automatic test_mul();
        issue(1'b0, 16'd3, 16'hFFFC, 1'b1, mk(16'hFFF4, 16'hFFFF, 1'b0, 1'b0));
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_run got busy=%b stall=%b want 1 1", busy, stall);
        end
        wait_done(40);
        issue(1'b0, 16'd300, 16'd300, 1'b1, mk(16'h5F90, 16'h0001, 1'b0, 1'b1));
        wait_done(40);
        issue_model(1'b0, 16'h8000, 16'h8000);
        wait_done(40);
    endtask

    task automatic test_div();
        issue(1'b1, 16'hFFF9, 16'd2, 1'b1, mk(16'hFFFD, 16'hFFFF, 1'b0, 1'b0));
        wait_done(40);
        issue(1'b1, 16'h8000, 16'hFFFF, 1'b1, mk(16'h8000, 16'h0000, 1'b0, 1'b1));
        wait_done(40);
    endtask

    task automatic test_div0();
        issue(1'b1, 16'd5, 16'd0, 1'b1, mk(16'h0, 16'h0, 1'b1, 1'b0));
        wait_done(5);
    endtask

    task automatic test_flush();
        issue(1'b0, 16'd1234, 16'd3, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b0));
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_flush got=%b want=1", busy);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_flush got busy=%b stall=%b want 0 0", busy, stall);
        end
        expect_no_done(25, "flush_no_done");
        checks++;
        if (result_lo !== last_exp.lo || result_hi !== last_exp.hi ||
            div0 !== last_exp.dz || overflow !== last_exp.ov) begin
            failures++;
            $display("FAIL flush_hold got lo=%h hi=%h div0=%b ovf=%b want lo=%h hi=%h div0=%b ovf=%b",
                     result_lo, result_hi, div0, overflow,
                     last_exp.lo, last_exp.hi, last_exp.dz, last_exp.ov);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 16'd7, 16'hFFF7, 1'b1, mk(16'hFFC1, 16'hFFFF, 1'b0, 1'b0));
        repeat (16) @(posedge clk);
        issue(1'b1, 16'd100, 16'd7, 1'b1, mk(16'd14, 16'd2, 1'b0, 1'b0));
        wait_done(40);
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 16'd1000, 16'd3, 1'b0, mk(16'h0, 16'h0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("reset_mid_run");
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_no_done(25, "reset_mid_no_done");
    endtask

    task automatic test_random();
        logic d;
        logic [15:0] aa, bb;
        for (int i = 0; i < 6; i++) begin
            d  = 1'($urandom_range(0, 1));
            aa = 16'($urandom);
            bb = 16'($urandom);
            issue_model(d, aa, bb);
            wait_done(40);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div0();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
